// File: rtl/edulent_pkg.sv
// edulent_pkg: shared widths, fetch FSM states and opcode helpers for fetch and control units
package edulent_pkg;
  localparam int ADDR_W_DFLT = 8;
  localparam int DATA_W_DFLT = 8;
  typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_ARG, READY} fetch_state_t;
  localparam logic [DATA_W_DFLT-1:0] OP_CALL = 8'hC1;
  // Opcodes with the top bit set carry one operand byte
  function automatic logic has_operand(input logic [DATA_W_DFLT-1:0] op);
    return op[DATA_W_DFLT-1];
  endfunction
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetches opcode plus optional operand over req/ack, holds it until consumed, owns the PC
module instr_fetch
  import edulent_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_opcode,
  output logic [DATA_W-1:0] o_operand,
  output logic              o_instr_valid,
  input  logic              i_next_instr,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_target,
  output logic [ADDR_W-1:0] o_pc
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d, operand_q, operand_d;
  logic              op_ack, arg_ack;

  assign op_ack  = state_q == FETCH_OP && i_mem_ack;
  assign arg_ack = state_q == FETCH_ARG && i_mem_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  always_comb begin
    state_d = state_q == IDLE                 ? FETCH_OP :
              op_ack                          ? (has_operand(i_mem_data) ? FETCH_ARG : READY) :
              arg_ack                         ? READY :
              state_q == READY && i_next_instr ? FETCH_OP :
                                                state_q;
  end

  always_comb begin
    pc_d      = (op_ack || arg_ack)              ? pc_q + ADDR_W'(1) :
                (state_q == READY && i_pc_load) ? i_pc_target : pc_q;
    opcode_d  = op_ack ? i_mem_data : opcode_q;
    operand_d = op_ack ? '0 : arg_ack ? i_mem_data : operand_q;
  end

  always_comb begin
    o_mem_req     = state_q == FETCH_OP || state_q == FETCH_ARG;
    o_instr_valid = state_q == READY;
    o_mem_addr    = pc_q;
    o_pc          = pc_q;
    o_opcode      = opcode_q;
    o_operand     = operand_q;
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a small req/ack memory responder
module tb_instr_fetch;
  import edulent_pkg::*;
  logic       clk = 0, rst = 1;
  logic       mem_req, mem_ack = 0, instr_valid, next_instr = 0, pc_load = 0;
  logic [7:0] mem_addr, mem_data = 0, opcode, operand, pc_target = 0, pc;
  logic [7:0] mem [256];
  logic [7:0] req_log [$];
  int         ack_delay = 1, wait_cnt = 0, checks = 0, failures = 0;
  bit         mem_en = 1;

  instr_fetch dut (
    .i_clk(clk), .i_rst(rst), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data), .o_opcode(opcode), .o_operand(operand),
    .o_instr_valid(instr_valid), .i_next_instr(next_instr), .i_pc_load(pc_load),
    .i_pc_target(pc_target), .o_pc(pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 0;
      wait_cnt = 0;
    end else if (mem_en && mem_req) begin
      if (wait_cnt == ack_delay) begin
        mem_ack  = 1;
        mem_data = mem[mem_addr];
        req_log.push_back(mem_addr);
      end else wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    chk({tag, "_valid"}, instr_valid, 1);
  endtask

  task automatic pulse_next(input logic load, input logic [7:0] target);
    next_instr = 1;
    pc_load    = load;
    pc_target  = target;
    step();
    next_instr = 0;
    pc_load    = 0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;
    mem[8'h01] = OP_CALL;
    mem[8'h02] = 8'h40;
    mem[8'h40] = 8'h05;
    mem[8'hFF] = OP_CALL;
    step();
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_pc", pc, 0);
    rst = 0;
    wait_valid("t1");
    chk("t1_opcode", opcode, 8'h10);
    chk("t1_operand", operand, 8'h00);
    chk("t1_pc", pc, 8'h01);
    chk("t1_nreq", req_log.size(), 1);
    chk("t1_addr", req_log[0], 8'h00);
    req_log.delete();
    pulse_next(0, 0);
    chk("t2_valid_fall", instr_valid, 0);
    wait_valid("t2");
    chk("t2_opcode", opcode, 8'hC1);
    chk("t2_operand", operand, 8'h40);
    chk("t2_pc", pc, 8'h03);
    chk("t2_nreq", req_log.size(), 2);
    chk("t2_addr0", req_log[0], 8'h01);
    chk("t2_addr1", req_log[1], 8'h02);
    req_log.delete();
    pulse_next(1, 8'h40);
    chk("t3_valid_fall", instr_valid, 0);
    chk("t3_addr", mem_addr, 8'h40);
    wait_valid("t3");
    chk("t3_req_addr", req_log[0], 8'h40);
    chk("t3_opcode", opcode, 8'h05);
    chk("t3_operand", operand, 8'h00);
    chk("t3_pc", pc, 8'h41);
    pc_load   = 1;
    pc_target = 8'hFF;
    step();
    pc_load = 0;
    chk("t4_load_pc", pc, 8'hFF);
    chk("t4_load_valid", instr_valid, 1);
    mem[8'h00] = 8'h22;
    pulse_next(0, 0);
    wait_valid("t4");
    chk("t4_opcode", opcode, 8'hC1);
    chk("t4_operand", operand, 8'h22);
    chk("t4_pc", pc, 8'h01);
    mem[8'h01] = 8'h11;
    ack_delay  = 3;
    pulse_next(0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_req", mem_req, 1);
      chk("t5_addr", mem_addr, 8'h01);
      chk("t5_pc", pc, 8'h01);
      chk("t5_valid", instr_valid, 0);
      step();
    end
    wait_valid("t5");
    chk("t5_opcode", opcode, 8'h11);
    chk("t5_pc_after", pc, 8'h02);
    mem[8'h02] = 8'h85;
    ack_delay  = 1;
    pulse_next(0, 0);
    for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'h03); i++) step();
    chk("t6_in_arg", mem_addr, 8'h03);
    mem_en = 0;
    rst    = 1;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_opcode", opcode, 0);
    chk("t6_rst_operand", operand, 0);
    chk("t6_rst_valid", instr_valid, 0);
    step();
    mem_ack  = 1;
    mem_data = 8'h99;
    step();
    rst = 0;
    step();
    mem_ack = 0;
    chk("t6_late_opcode", opcode, 0);
    chk("t6_late_pc", pc, 0);
    chk("t6_req", mem_req, 1);
    chk("t6_addr", mem_addr, 0);
    req_log.delete();
    wait_cnt = 0;
    mem_en   = 1;
    wait_valid("t6");
    chk("t6_opcode", opcode, 8'h22);
    chk("t6_pc", pc, 8'h01);
    chk("t6_req_addr", req_log.size() > 0 ? req_log[0] : 8'hEE, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
